// File: rtl/seg7_sequence_player.sv
// ============================================================================
// Module   : seg7_sequence_player
// Purpose  : Plays a stored digit pattern onto one 7-segment decoder, each
//            digit shown for ON_CYCLES followed by an OFF_CYCLES blank gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_sequence_player #(
    parameter logic [31:0] ON_CYCLES  = 32'd25000000,
    parameter logic [31:0] OFF_CYCLES = 32'd12500000,
    parameter int          MAX_LEN    = 16,
    parameter int          IDX_W      = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_En,
    input  logic [IDX_W-1:0] i_Wr_Addr,
    input  logic [3:0]       i_Wr_Data,
    input  logic [IDX_W:0]   i_Len,
    input  logic             i_Start,
    input  logic             i_Abort,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [3:0]       o_Digit,
    output logic             o_Digit_Valid,
    output logic [IDX_W-1:0] o_Index
);

    localparam logic [IDX_W:0] c_MAX_LEN = (IDX_W+1)'(MAX_LEN);
    localparam logic [3:0]     c_BLANK   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHOW   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_cnt, w_cnt_nxt;
    logic [IDX_W:0]   r_len, w_len_nxt;
    logic             w_busy_nxt, w_done_nxt, w_valid_nxt;
    logic [3:0]       w_digit_nxt;
    logic [IDX_W-1:0] w_index_nxt;

    logic [3:0]       r_mem [MAX_LEN];
    logic [IDX_W:0]   w_len_clamped;
    logic [3:0]       w_first_digit;
    logic [IDX_W-1:0] w_next_index;
    logic             w_more_digits;

    // Pattern memory is deliberately left out of reset so a pattern survives it.
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En && !o_Busy) begin
            r_mem[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign w_len_clamped = (i_Len > c_MAX_LEN) ? c_MAX_LEN : i_Len;
    // A write landing on the same edge as start must be the value that plays.
    assign w_first_digit = (i_Wr_En && (i_Wr_Addr == '0)) ? i_Wr_Data : r_mem[0];
    assign w_next_index  = o_Index + IDX_W'(1);
    assign w_more_digits = (({1'b0, o_Index} + (IDX_W+1)'(1)) < r_len);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_len         <= '0;
            o_Busy        <= 1'b0;
            o_Done        <= 1'b0;
            o_Digit       <= c_BLANK;
            o_Digit_Valid <= 1'b0;
            o_Index       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_len         <= w_len_nxt;
            o_Busy        <= w_busy_nxt;
            o_Done        <= w_done_nxt;
            o_Digit       <= w_digit_nxt;
            o_Digit_Valid <= w_valid_nxt;
            o_Index       <= w_index_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_busy_nxt  = o_Busy;
        w_done_nxt  = 1'b0;
        w_digit_nxt = o_Digit;
        w_valid_nxt = o_Digit_Valid;
        w_index_nxt = o_Index;

        if ((r_state != S_IDLE) && i_Abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_digit_nxt = c_BLANK;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_busy_nxt  = 1'b0;
                    w_digit_nxt = c_BLANK;
                    w_valid_nxt = 1'b0;
                    if (i_Start && !i_Abort) begin
                        if (w_len_clamped == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_SHOW;
                            w_cnt_nxt   = '0;
                            w_len_nxt   = w_len_clamped;
                            w_busy_nxt  = 1'b1;
                            w_index_nxt = '0;
                            w_digit_nxt = w_first_digit;
                            w_valid_nxt = 1'b1;
                        end
                    end
                end
                S_SHOW: begin
                    if (r_cnt == ON_CYCLES - 32'd1) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = '0;
                        w_digit_nxt = c_BLANK;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == OFF_CYCLES - 32'd1) begin
                        w_cnt_nxt = '0;
                        if (w_more_digits) begin
                            w_state_nxt = S_SHOW;
                            w_index_nxt = w_next_index;
                            w_digit_nxt = r_mem[w_next_index];
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_FINISH;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                S_FINISH: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_sequence_player.sv
// ============================================================================
// Module   : tb_seg7_sequence_player
// Purpose  : Scoreboard bench for seg7_sequence_player (ON=3, OFF=2, 4 digits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_sequence_player;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_DONE = 2;
    localparam int PER    = 5;

    typedef struct {
        int kind;
        int cyc;
        int digit;
        int index;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [2:0] len = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, digit_valid;
    logic [3:0] digit;
    logic [1:0] index;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    logic [3:0] model [4];

    seg7_sequence_player #(
        .ON_CYCLES (32'd3),
        .OFF_CYCLES(32'd2),
        .MAX_LEN   (4),
        .IDX_W     (2)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Wr_En      (wr_en),
        .i_Wr_Addr    (wr_addr),
        .i_Wr_Data    (wr_data),
        .i_Len        (len),
        .i_Start      (start),
        .i_Abort      (abort),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Digit      (digit),
        .o_Digit_Valid(digit_valid),
        .o_Index      (index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int d, input int i, input int b);
        exp_t e;
        e.kind = k; e.cyc = c; e.digit = d; e.index = i; e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic push_full(input int c0, input int l);
        for (int k = 0; k < l; k++) begin
            push(K_RISE, c0 + 1 + PER*k, int'(model[k]), k, 1);
            push(K_FALL, c0 + 4 + PER*k, 15, -1, 1);
        end
        push(K_DONE, c0 + 1 + PER*l, 15, (l > 0) ? l - 1 : -1, 0);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind=%0d at cyc %0d digit=%h, required no event", kind, cyc, digit);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.digit != int'(digit) || e.busy != int'(busy) ||
                (e.index >= 0 && e.index != int'(index))) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d digit=%h idx=%0d busy=%0d, required kind=%0d cyc=%0d digit=%h idx=%0d busy=%0d",
                         kind, cyc, digit, index, busy, e.kind, e.cyc, e.digit, e.index, e.busy);
            end
        end
    endtask

    // Monitor: each visible output event pops and checks the next expectation.
    always @(negedge clk) begin
        if (digit_valid && !prev_valid) check_event(K_RISE);
        if (!digit_valid && prev_valid) check_event(K_FALL);
        if (done) check_event(K_DONE);
        prev_valid <= digit_valid;
    end

    task automatic write_mem(input int a, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d[3:0];
        model[a] = d[3:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge of the first displayed cycle (c0+1).
    task automatic do_start(input int l, input bit full, output int c0);
        int lc;
        @(negedge clk);
        len = l[2:0]; start = 1'b1; c0 = cyc;
        lc = (l > 4) ? 4 : l;
        if (full) push_full(c0, lc);
        else push(K_RISE, c0 + 1, int'(model[0]), 0, 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_digit", int'(digit), 15);
        chk("reset_valid", int'(digit_valid), 0);
        chk("reset_index", int'(index), 0);
        rst_n = 1'b1;

        // Basic three-digit playback.
        write_mem(0, 5); write_mem(1, 2); write_mem(2, 9); write_mem(3, 7);
        do_start(3, 1'b1, c0);
        repeat (3*PER + 2) @(negedge clk);

        // Write and second start while busy are both ignored.
        do_start(3, 1'b1, c0);
        repeat (3) @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd8; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        repeat (3*PER) @(negedge clk);
        do_start(1, 1'b1, c0);
        repeat (PER + 2) @(negedge clk);

        // Write and start on the same edge plays the new value.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd6; model[0] = 4'd6;
        len = 3'd1; start = 1'b1; c0 = cyc;
        push_full(c0, 1);
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        repeat (PER + 2) @(negedge clk);

        // Length beyond MAX_LEN is clamped.
        write_mem(0, 1); write_mem(1, 2); write_mem(2, 3); write_mem(3, 4);
        do_start(7, 1'b1, c0);
        repeat (4*PER + 2) @(negedge clk);
        chk("len7_index_hold", int'(index), 3);

        // Zero length: immediate done, no playback.
        do_start(0, 1'b1, c0);
        chk("len0_busy", int'(busy), 0);
        repeat (4) @(negedge clk);

        // Abort during the second SHOW.
        do_start(3, 1'b0, c0);
        push(K_FALL, c0 + 4, 15, -1, 1);
        push(K_RISE, c0 + 6, 2, 1, 1);
        push(K_FALL, c0 + 8, 15, -1, 0);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_digit", int'(digit), 15);
        chk("abort_valid", int'(digit_valid), 0);
        repeat (12) @(negedge clk);

        // Start together with abort in IDLE is ignored.
        len = 3'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (8) @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);

        // Asynchronous reset mid-SHOW, then replay from retained memory.
        do_start(4, 1'b0, c0);
        @(negedge clk);
        push(K_FALL, c0 + 3, 15, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_digit", int'(digit), 15);
        chk("async_rst_valid", int'(digit_valid), 0);
        chk("async_rst_index", int'(index), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_start(2, 1'b1, c0);
        repeat (2*PER + 3) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_sequence_player.md
Name: seg7_sequence_player

Overview:
Plays a stored sequence of 4-bit digits onto a single seven-segment decoder for the memory game. Each digit is shown for a fixed on-time, followed by a blank gap.
- Sits between the game FSM and the binary-to-7-segment decoder.
- The game FSM loads the pattern, pulses start and waits for done.
- o_Digit drives the decoder's binary number input directly. Value 4'hF blanks the display.

Parameters:
ON_CYCLES, 25000000, clocks each digit is displayed; legal range 1 to 2^32-1
OFF_CYCLES, 12500000, clocks of blank gap after each digit; legal range 1 to 2^32-1
MAX_LEN, 16, pattern memory depth in digits; must be a power of 2, at least 2
IDX_W, 4, index width; must equal log2(MAX_LEN)

Ports:
i_Clk  in  1  system clock; single clock domain
i_Rst_L  in  1  asynchronous active-low reset
i_Wr_En  in  1  pattern memory write strobe
i_Wr_Addr  in  IDX_W  pattern memory write address
i_Wr_Data  in  4  digit to store
i_Len  in  IDX_W+1  number of digits to play
i_Start  in  1  start playback, level-sampled
i_Abort  in  1  cancel playback
o_Busy  out  1  playback in progress
o_Done  out  1  one-cycle pulse at normal completion
o_Digit  out  4  digit code to decoder; 4'hF = blank
o_Digit_Valid  out  1  high while a digit (not blank) is shown
o_Index  out  IDX_W  index of the current or most recent digit

Behaviour:
Reset and interface:
- Reset (i_Rst_L=0, asynchronous): state IDLE, o_Busy=0, o_Done=0, o_Digit=4'hF, o_Digit_Valid=0, o_Index=0, counters=0. Pattern memory contents are not reset.
- Reset mid-playback aborts immediately; no o_Done pulse is produced.
- All outputs are registered.

Pattern memory:
- MAX_LEN x 4 bits.
- A write occurs on a clock edge with i_Wr_En=1 only while o_Busy=0; writes while busy are dropped.

States:
IDLE, SHOW, GAP, FINISH.

IDLE:
- Holds o_Digit=4'hF and o_Digit_Valid=0.
- i_Start=1 at edge T with latched length L>0:
  - L = min(i_Len, MAX_LEN), latched at T.
  - At T+1: state SHOW, o_Busy=1, o_Index=0, o_Digit=mem[0], o_Digit_Valid=1.
- i_Start with i_Len=0: no playback; o_Done=1 at T+1 for one cycle; o_Busy stays 0.
- If i_Wr_En and i_Start are high in the same cycle, the write completes first, so the written value is the one played.

SHOW:
- Lasts exactly ON_CYCLES clocks, then transitions to GAP.
- On entering GAP: o_Digit=4'hF, o_Digit_Valid=0.

GAP:
- Lasts exactly OFF_CYCLES clocks.
- If o_Index < L-1: increment o_Index and enter SHOW with the next digit.
- Otherwise: enter FINISH.

FINISH:
- Lasts one cycle: o_Done=1, o_Busy=0, o_Digit=4'hF. Then returns to IDLE.
- o_Index holds L-1 until the next start.

Timing and control rules:
- Digit k is visible from T+1+k*(ON+OFF) for ON cycles.
- o_Done is asserted at T+1+L*(ON+OFF).
- i_Start while busy is ignored; it does not restart playback.
- i_Abort has priority over all other inputs in every non-IDLE state. On the next cycle: IDLE, o_Busy=0, o_Digit=4'hF, o_Digit_Valid=0, no o_Done pulse.
- i_Abort in IDLE has no effect; if i_Start is asserted with it in the same cycle, the start is ignored.

Counters:
- Phase counter is 32 bits, loaded with 0 on each phase entry.
- Phase ends when count == phase_length-1.
- The index counter never wraps during playback because L <= MAX_LEN.

Test Plan:
(All scenarios use ON=3, OFF=2, MAX_LEN=4, IDX_W=2.)
- Write mem=[5,2,9,7], i_Len=3, pulse start at T:
  - o_Digit is 5 at T+1..T+3, F at T+4..T+5, 2 at T+6..T+8, F, 9 at T+11..T+13, F.
  - o_Done=1 exactly at T+16; o_Busy=1 over T+1..T+15.
- i_Len=7 (greater than MAX_LEN) with mem=[1,2,3,4] -> plays 1,2,3,4; o_Done at T+21; o_Index ends at 3.
- i_Len=0, start -> o_Done=1 at T+1 only; o_Busy never 1; o_Digit stays F.
- Start, then i_Abort asserted during the second SHOW -> next cycle o_Busy=0, o_Digit=F, o_Digit_Valid=0; o_Done never pulses.
- Write addr0=8 while busy, plus a second start during GAP -> playback is unchanged. A later replay shows the old mem[0].
- Assert i_Rst_L low asynchronously mid-SHOW -> outputs go to reset values immediately. After release, a start replays the pattern correctly because memory is retained.
